// File: rtl/shift_add_mult.sv
// shift_add_mult
//   Sequential shift-add multiplier. One multiplier bit is consumed per clock,
//   so a single A_W+B_W adder serves every multiplier width. An accepted start
//   runs for exactly B_W cycles. The final cycle raises a one-cycle done pulse
//   and loads a registered product, resized to P_W, together with an overflow
//   flag.
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   operation request, sampled only while not busy
//   a        in   A_W-bit unsigned multiplicand, captured on accepted start
//   b        in   B_W-bit unsigned multiplier, captured on accepted start
//   busy     out  high while an operation is running
//   done     out  one-cycle pulse when product/overflow have just updated
//   product  out  P_W-bit registered result, held until next completion
//   overflow out  set when the full product does not fit in P_W bits
module shift_add_mult #(
  parameter int A_W = 16,
  parameter int B_W = 4,
  parameter int P_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product,
  output logic           overflow
);

  localparam int AB_W  = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);
  localparam int MAX_W = (P_W > AB_W) ? P_W : AB_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AB_W-1:0]   a_q, a_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [AB_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [P_W-1:0]    product_q, product_d;
  logic              overflow_q, overflow_d;
  logic [AB_W-1:0]   acc_sum;

  // Widen first so that both truncation and zero-extension pick the low P_W bits.
  function automatic logic [P_W-1:0] fit_product(input logic [AB_W-1:0] full);
    logic [MAX_W-1:0] ext;
    ext = MAX_W'(full);
    return ext[P_W-1:0];
  endfunction

  // Any bit above P_W-1 being set means the result was truncated. When
  // P_W >= AB_W, the shift clears every bit and the flag stays at 0.
  function automatic logic fit_overflow(input logic [AB_W-1:0] full);
    return (full >> P_W) != '0;
  endfunction

  // a_q is A_W+B_W wide, so the left shifts never drop a multiplicand bit.
  assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    product_d  = product_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {{B_W{1'b0}}, a};
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          product_d  = fit_product(acc_sum);
          overflow_d = fit_overflow(acc_sum);
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult. Four instances are used:
//   0: 16x4 -> 32 (main), 1: 16x4 -> 16 (truncating),
//   2: 16x1 -> 32,        3: 16x8 -> 20 (truncating).
// Stimulus pushes {instance, product, overflow, cycle} entries. A negedge
// monitor pops one entry on every done pulse and compares it.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_in;
  logic [3:0]  b4;
  logic [0:0]  b1;
  logic [7:0]  b8;
  logic        st [4];
  logic        bz [4];
  logic        dn [4];
  logic        ov [4];
  logic [31:0] pr [4];
  logic [31:0] hp [4];

  logic [31:0] p_m;
  logic [15:0] p_16;
  logic [31:0] p_1;
  logic [19:0] p_8;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          id;
    logic [31:0] p;
    logic        ovf;
    int          t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  shift_add_mult #(.A_W(16), .B_W(4), .P_W(32)) u_main (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(a_in), .b(b4),
    .busy(bz[0]), .done(dn[0]), .product(p_m), .overflow(ov[0]));
  shift_add_mult #(.A_W(16), .B_W(4), .P_W(16)) u_p16 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(a_in), .b(b4),
    .busy(bz[1]), .done(dn[1]), .product(p_16), .overflow(ov[1]));
  shift_add_mult #(.A_W(16), .B_W(1), .P_W(32)) u_b1 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(a_in), .b(b1),
    .busy(bz[2]), .done(dn[2]), .product(p_1), .overflow(ov[2]));
  shift_add_mult #(.A_W(16), .B_W(8), .P_W(20)) u_b8 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .a(a_in), .b(b8),
    .busy(bz[3]), .done(dn[3]), .product(p_8), .overflow(ov[3]));

  assign pr[0] = p_m;
  assign pr[1] = 32'(p_16);
  assign pr[2] = p_1;
  assign pr[3] = 32'(p_8);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dn[k] === 1'b1) begin
        if (sb.size() == 0 || sb[0].id != k) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done inst %0d @cycle %0d: got done=1, expected done=0", k, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("done_cycle[%0d]", k), 32'(cyc), 32'(e.t));
          chk($sformatf("product[%0d]", k), pr[k], e.p);
          chk($sformatf("overflow[%0d]", k), 32'(ov[k]), 32'(e.ovf));
        end
      end
    end
    if (sb.size() != 0 && sb[0].t < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_done inst %0d @cycle %0d: got no done, expected done at cycle %0d", sb[0].id, cyc, sb[0].t);
      void'(sb.pop_front());
    end
  end

  // Called on a negedge with instance k idle. Returns on the done negedge, so
  // a following call issues start exactly in the done cycle.
  task automatic op(input int k, input logic [15:0] av, input logic [7:0] bv,
                    input int bw, input logic [31:0] ep, input logic eo);
    exp_t e;
    a_in = av;
    b4 = bv[3:0];
    b1 = bv[0];
    b8 = bv;
    st[k] = 1'b1;
    e.id = k; e.p = ep; e.ovf = eo; e.t = cyc + 1 + bw;
    sb.push_back(e);
    @(negedge clk);
    st[k] = 1'b0;
    for (int i = 0; i < bw; i++) begin
      chk($sformatf("busy_run[%0d]", k), 32'(bz[k]), 32'd1);
      chk($sformatf("product_held[%0d]", k), pr[k], hp[k]);
      @(negedge clk);
    end
    chk($sformatf("busy_end[%0d]", k), 32'(bz[k]), 32'd0);
    hp[k] = ep;
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [31:0] full;
    exp_t e;

    rst_n = 1'b0;
    a_in = '0; b4 = '0; b1 = '0; b8 = '0;
    for (int k = 0; k < 4; k++) begin
      st[k] = 1'b0;
      hp[k] = '0;
    end
    #1;
    chk("reset_busy", 32'(bz[0]), 32'd0);
    chk("reset_done", 32'(dn[0]), 32'd0);
    chk("reset_product", pr[0], 32'd0);
    chk("reset_overflow", 32'(ov[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones operands, then a start in the done cycle
    op(0, 16'hFFFF, 8'h0F, 4, 32'h000EFFF1, 1'b0);
    op(0, 16'h0002, 8'h09, 4, 32'd18, 1'b0);
    // Zero operands still take the full latency
    op(0, 16'h0000, 8'h0F, 4, 32'd0, 1'b0);
    op(0, 16'hABCD, 8'h00, 4, 32'd0, 1'b0);
    @(negedge clk);

    // Start held high, operands changed while busy
    a_in = 16'd5; b4 = 4'd3; st[0] = 1'b1;
    e.id = 0; e.p = 32'd15; e.ovf = 1'b0; e.t = cyc + 5;
    sb.push_back(e);
    @(negedge clk);
    a_in = 16'd7; b4 = 4'd7;
    repeat (3) @(negedge clk);
    chk("held_start_busy", 32'(bz[0]), 32'd1);
    @(negedge clk);
    chk("held_start_idle_in_done", 32'(bz[0]), 32'd0);
    e.id = 0; e.p = 32'd49; e.ovf = 1'b0; e.t = cyc + 5;
    sb.push_back(e);
    @(negedge clk);
    st[0] = 1'b0;
    chk("held_start_second_busy", 32'(bz[0]), 32'd1);
    chk("held_start_product_kept", pr[0], 32'd15);
    repeat (4) @(negedge clk);
    @(negedge clk);

    // Reset asserted two cycles into an operation
    a_in = 16'hFFFF; b4 = 4'hF; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bz[0]), 32'd0);
    chk("abort_done", 32'(dn[0]), 32'd0);
    chk("abort_product", pr[0], 32'd0);
    chk("abort_overflow", 32'(ov[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) hp[k] = '0;
    repeat (8) @(negedge clk);
    chk("abort_no_result", pr[0], 32'd0);

    // Truncating 16-bit product
    op(1, 16'hFFFF, 8'h0F, 4, 32'h0000FFF1, 1'b1);
    op(1, 16'h1234, 8'h03, 4, 32'h0000369C, 1'b0);
    @(negedge clk);

    // B_W=1 sweep
    op(2, 16'hFFFF, 8'h01, 1, 32'h0000FFFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(0, 1));
      full = 32'(ra) * 32'(rb);
      op(2, ra, rb, 1, full, 1'b0);
    end
    @(negedge clk);

    // B_W=8 sweep, 20-bit product
    op(3, 16'hFFFF, 8'hFF, 8, 32'h000EFF01, 1'b1);
    op(3, 16'h0010, 8'h10, 8, 32'h00000100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      full = 32'(ra) * 32'(rb);
      op(3, ra, rb, 8, full & 32'h000F_FFFF, (full >> 20) != 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
